ahb_sram_slave: RTL

//  AHB-Lite responder: the slave end of the bus driven by the Ibex-to-AHB bridge.

---
 rtl/ahb_sram_slave.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-organised RAM with byte/halfword/word writes,
// a fixed number of wait states per OKAY data phase and the two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          ADDR_LSB  = 2;
  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U   = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [3:0]       r_waitCnt;
  logic [3:0]       w_waitCntNext;

  logic             r_dpValid;
  logic             r_dpWrite;
  logic [1:0]       r_dpSize;
  logic [1:0]       r_dpLane;
  logic [IDX_W-1:0] r_dpIndex;

  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_slaveReady;
  logic             w_accept;
  logic             w_reqBad;
  logic             w_goodAccept;
  logic             w_badAccept;
  logic             w_dataDone;
  logic             w_commit;
  logic [31:0]      w_wordIdx;
  logic [3:0]       w_byteEn;

  assign w_slaveReady = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign w_accept     = HSEL && HREADY && HTRANS[1] && w_slaveReady;
  assign w_wordIdx    = {2'b00, HADDR[31:2]};

  always_comb begin
    w_reqBad = 1'b0;
    if (HSIZE > 3'd2) begin
      w_reqBad = 1'b1;
    end
    if ((HSIZE == 3'd1) && HADDR[0]) begin
      w_reqBad = 1'b1;
    end
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) begin
      w_reqBad = 1'b1;
    end
    if (w_wordIdx >= DEPTH_U) begin
      w_reqBad = 1'b1;
    end
  end

  assign w_goodAccept = w_accept && !w_reqBad;
  assign w_badAccept  = w_accept && w_reqBad;

  // An OKAY data phase finishes on the edge at the end of the cycle it is back in IDLE.
  assign w_dataDone = r_dpValid && (r_state == S_IDLE);
  assign w_commit   = w_dataDone && r_dpWrite;

  always_comb begin
    w_stateNext   = r_state;
    w_waitCntNext = r_waitCnt;
    case (r_state)
      S_IDLE, S_ERR2: begin
        w_stateNext = S_IDLE;
        if (w_badAccept) begin
          w_stateNext = S_ERR1;
        end else if (w_goodAccept && (WAIT_STATES > 0)) begin
          w_stateNext   = S_WAIT;
          w_waitCntNext = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (r_waitCnt <= 4'd1) begin
          w_stateNext   = S_IDLE;
          w_waitCntNext = 4'd0;
        end else begin
          w_waitCntNext = r_waitCnt - 4'd1;
        end
      end
      S_ERR1: begin
        w_stateNext = S_ERR2;
      end
      default: begin
        w_stateNext   = S_IDLE;
        w_waitCntNext = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_waitCnt <= 4'd0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitCntNext;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dpValid <= 1'b0;
      r_dpWrite <= 1'b0;
      r_dpSize  <= 2'd0;
      r_dpLane  <= 2'd0;
      r_dpIndex <= '0;
    end else begin
      if (w_accept) begin
        r_dpWrite <= HWRITE;
        r_dpSize  <= HSIZE[1:0];
        r_dpLane  <= HADDR[1:0];
        r_dpIndex <= HADDR[ADDR_LSB +: IDX_W];
      end
      if (w_goodAccept) begin
        r_dpValid <= 1'b1;
      end else if (w_dataDone) begin
        r_dpValid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_byteEn = 4'b1111;
    case (r_dpSize)
      2'd0:    w_byteEn = 4'b0001 << r_dpLane;
      2'd1:    w_byteEn = r_dpLane[1] ? 4'b1100 : 4'b0011;
      default: w_byteEn = 4'b1111;
    endcase
  end

  // RAM contents survive reset; HWDATA is only looked at on the completing edge.
  always_ff @(posedge clk_i) begin
    if (w_commit && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byteEn[b]) begin
          r_mem[r_dpIndex][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HREADYOUT = w_slaveReady;
  assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign HRDATA    = (r_dpValid && !r_dpWrite) ? r_mem[r_dpIndex] : 32'd0;

endmodule
